// File: rtl/day6_pkg.sv
// Shared constants and width-checked arithmetic helpers for the Day 6 solver.
// Helpers work on MAX_W-bit containers; the caller passes its real width w (<= MAX_W).
package day6_pkg;
    localparam int DIGIT_W = 4;
    localparam int MAX_W   = 64;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] val;
    } arith_t;

    function automatic logic [MAX_W-1:0] w_mask(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic arith_t mul10(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W+3:0] xe;
        logic [MAX_W+3:0] t;
        arith_t           r;
        xe    = {4'b0, x};
        t     = (xe << 3) + (xe << 1);
        r.ovf = |(t >> w);
        r.val = t[MAX_W-1:0] & w_mask(w);
        return r;
    endfunction

    function automatic arith_t add_w(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                     input int w);
        logic [MAX_W:0] t;
        arith_t         r;
        t     = {1'b0, a} + {1'b0, b};
        r.ovf = |(t >> w);
        r.val = t[MAX_W-1:0] & w_mask(w);
        return r;
    endfunction

    function automatic arith_t mul_w(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                     input int w);
        logic [2*MAX_W-1:0] p;
        arith_t             r;
        p     = {{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, b};
        r.ovf = |(p >> w);
        r.val = p[MAX_W-1:0] & w_mask(w);
        return r;
    endfunction
endpackage

// File: rtl/day6_row_acc.sv
// Per-row number builder: holds R[r] and offers the value after the current column.
module day6_row_acc
    import day6_pkg::*;
#(
    parameter int W = 64
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               en,
    input  logic               start,
    input  logic               blank,
    input  logic [DIGIT_W-1:0] digit,
    output logic [W-1:0]       r_next,
    output logic               ovf
);
    logic [W-1:0] r_q;
    logic [W-1:0] base;
    arith_t       m;
    arith_t       a;

    always_comb begin
        base   = start ? '0 : r_q;
        m      = mul10(MAX_W'(base), W);
        a      = add_w(m.val, MAX_W'(digit), W);
        r_next = blank ? base : W'(a.val);
        ovf    = ~blank & (m.ovf | a.ovf);
    end

    always_ff @(posedge clock) begin
        if (clear)   r_q <= '0;
        else if (en) r_q <= r_next;
    end
endmodule

// File: rtl/day6_solver_n.sv
// Streaming N-row Day 6 solver: column fold, block reduction, result register and totals.
module day6_solver_n
    import day6_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    col_valid,
    output logic                    col_ready,
    input  logic [DIGIT_W*ROWS-1:0] col_digit,
    input  logic [ROWS-1:0]         col_space,
    input  logic                    block_start,
    input  logic                    block_plus,
    input  logic                    col_last,
    input  logic                    frame_last,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [W-1:0]            blk_p1,
    output logic [W-1:0]            blk_p2,
    output logic [W-1:0]            part1_result,
    output logic [W-1:0]            part2_result,
    output logic [CNT_W-1:0]        block_count,
    output logic                    overflow,
    output logic                    in_block,
    output logic                    done_
);
    logic                   rst, acc, s, op, op_reg;
    logic [ROWS-1:0][W-1:0] r_next;
    logic [ROWS-1:0]        r_ovf;
    logic [W-1:0]           b_q, b_base, b_next, col_num, p1;
    logic                   ovf_col, ovf_p1, ovf_beat;
    arith_t                 ab, t1, t2;

    assign rst       = clear | load;
    assign col_ready = ~done_ & ~load & (~blk_valid | blk_ready);
    assign acc       = col_valid & col_ready & ~clear;
    assign s         = block_start | ~in_block;
    assign op        = s ? block_plus : op_reg;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        day6_row_acc #(.W(W)) u_row (
            .clock  (clock),
            .clear  (rst),
            .en     (acc),
            .start  (s),
            .blank  (col_space[r]),
            .digit  (col_digit[DIGIT_W*r +: DIGIT_W]),
            .r_next (r_next[r]),
            .ovf    (r_ovf[r])
        );
    end

    always_comb begin
        arith_t t;
        t       = '0;
        col_num = '0;
        ovf_col = 1'b0;
        // Column value reads top to bottom; blank cells are skipped entirely.
        for (int r = 0; r < ROWS; r++) begin
            if (!col_space[r]) begin
                t       = mul10(MAX_W'(col_num), W);
                ovf_col = ovf_col | t.ovf;
                t       = add_w(t.val, MAX_W'(col_digit[DIGIT_W*r +: DIGIT_W]), W);
                ovf_col = ovf_col | t.ovf;
                col_num = W'(t.val);
            end
        end

        b_base = s ? (op ? '0 : W'(1)) : b_q;
        ab     = op ? add_w(MAX_W'(b_base), MAX_W'(col_num), W)
                    : mul_w(MAX_W'(b_base), MAX_W'(col_num), W);
        b_next = W'(ab.val);

        p1     = op ? '0 : W'(1);
        ovf_p1 = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            t      = op ? add_w(MAX_W'(p1), MAX_W'(r_next[r]), W)
                        : mul_w(MAX_W'(p1), MAX_W'(r_next[r]), W);
            ovf_p1 = ovf_p1 | t.ovf;
            p1     = W'(t.val);
        end

        t1       = add_w(MAX_W'(part1_result), MAX_W'(p1), W);
        t2       = add_w(MAX_W'(part2_result), MAX_W'(b_next), W);
        ovf_beat = (|r_ovf) | ovf_col | ab.ovf | (col_last & (ovf_p1 | t1.ovf | t2.ovf));
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            b_q          <= '0;
            op_reg       <= 1'b0;
            blk_valid    <= 1'b0;
            blk_p1       <= '0;
            blk_p2       <= '0;
            part1_result <= '0;
            part2_result <= '0;
            block_count  <= '0;
            overflow     <= 1'b0;
            in_block     <= 1'b0;
            done_        <= 1'b0;
        end else begin
            // A drain with no new result empties the register; a load overrides it.
            if (blk_valid && blk_ready) blk_valid <= 1'b0;
            if (acc) begin
                b_q      <= b_next;
                op_reg   <= op;
                overflow <= overflow | ovf_beat;
                if (col_last) begin
                    blk_p1       <= p1;
                    blk_p2       <= b_next;
                    blk_valid    <= 1'b1;
                    part1_result <= W'(t1.val);
                    part2_result <= W'(t2.val);
                    block_count  <= block_count + CNT_W'(1);
                    in_block     <= 1'b0;
                    if (frame_last) done_ <= 1'b1;
                end else begin
                    in_block <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_day6_solver_n.sv
// Scoreboard bench: expected block results are queued at stimulus time and popped on drain.
module tb_day6_solver_n;
    logic        clock = 1'b0;
    logic        clear, load, col_valid, block_start, block_plus, col_last, frame_last, blk_ready;
    logic [11:0] col_digit;
    logic [2:0]  col_space;
    logic        col_ready, blk_valid, overflow, in_block, done_;
    logic [63:0] blk_p1, blk_p2, part1_result, part2_result;
    logic [15:0] block_count;

    logic        b_clear, b_load, b_col_valid, b_start, b_plus, b_last, b_flast, b_blk_ready;
    logic [7:0]  b_digit;
    logic [1:0]  b_space;
    logic        b_col_ready, b_blk_valid, b_overflow, b_in_block, b_done;
    logic [15:0] b_p1, b_p2, b_part1, b_part2;
    logic [15:0] b_count;

    int          checks = 0;
    int          errors = 0;
    logic [127:0] exp_q[$];

    always #5 clock = ~clock;

    day6_solver_n #(.ROWS(3), .W(64), .CNT_W(16)) dut (
        .clock(clock), .clear(clear), .load(load), .col_valid(col_valid), .col_ready(col_ready),
        .col_digit(col_digit), .col_space(col_space), .block_start(block_start),
        .block_plus(block_plus), .col_last(col_last), .frame_last(frame_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_p1(blk_p1), .blk_p2(blk_p2),
        .part1_result(part1_result), .part2_result(part2_result), .block_count(block_count),
        .overflow(overflow), .in_block(in_block), .done_(done_)
    );

    day6_solver_n #(.ROWS(2), .W(16), .CNT_W(16)) dut_b (
        .clock(clock), .clear(b_clear), .load(b_load), .col_valid(b_col_valid),
        .col_ready(b_col_ready), .col_digit(b_digit), .col_space(b_space),
        .block_start(b_start), .block_plus(b_plus), .col_last(b_last), .frame_last(b_flast),
        .blk_valid(b_blk_valid), .blk_ready(b_blk_ready), .blk_p1(b_p1), .blk_p2(b_p2),
        .part1_result(b_part1), .part2_result(b_part2), .block_count(b_count),
        .overflow(b_overflow), .in_block(b_in_block), .done_(b_done)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [11:0] dg, input logic [2:0] sp, input logic st,
                        input logic pl, input logic last, input logic fl);
        int n = 0;
        col_valid = 1'b1; col_digit = dg; col_space = sp;
        block_start = st; block_plus = pl; col_last = last; frame_last = fl;
        @(negedge clock);
        while (!col_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!col_ready) chk("send_timeout", 64'(col_ready), 64'd1);
        @(posedge clock); #1;
        col_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (blk_valid && blk_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 64'(blk_valid), 64'd0);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                chk("sb_blk_p1", blk_p1, e[127:64]);
                chk("sb_blk_p2", blk_p2, e[63:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        clear = 1'b1; load = 1'b0; col_valid = 1'b0; col_digit = '0; col_space = '0;
        block_start = 1'b0; block_plus = 1'b0; col_last = 1'b0; frame_last = 1'b0;
        blk_ready = 1'b1;
        b_clear = 1'b1; b_load = 1'b0; b_col_valid = 1'b0; b_digit = '0; b_space = '0;
        b_start = 1'b0; b_plus = 1'b0; b_last = 1'b0; b_flast = 1'b0; b_blk_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0; b_clear = 1'b0;
        @(negedge clock);
        chk("rst_col_ready", 64'(col_ready), 64'd1);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_part1", part1_result, 64'd0);
        chk("rst_count", 64'(block_count), 64'd0);
        chk("rst_done", 64'(done_), 64'd0);
        chk("rst_in_block", 64'(in_block), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clock); #1;

        // Block 1: 123/45/6 multiply, held undrained afterwards
        blk_ready = 1'b0;
        send(12'h001, 3'b110, 1, 0, 0, 0);
        send(12'h042, 3'b100, 0, 0, 0, 0);
        exp_q.push_back({64'd33210, 64'd8544});
        send(12'h653, 3'b000, 0, 0, 1, 0);
        chk("lat_blk_valid", 64'(blk_valid), 64'd1);
        chk("lat_blk_p1", blk_p1, 64'd33210);
        chk("lat_blk_p2", blk_p2, 64'd8544);

        // Backpressure stall on block 2 first beat
        col_valid = 1'b1; col_digit = 12'h963; col_space = 3'b000;
        block_start = 1'b1; block_plus = 1'b1; col_last = 1'b0; frame_last = 1'b0;
        @(negedge clock);
        chk("stall_col_ready", 64'(col_ready), 64'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("stall_in_block", 64'(in_block), 64'd0);
        chk("stall_part1", part1_result, 64'd33210);
        chk("stall_count", 64'(block_count), 64'd1);
        @(posedge clock); #1;
        blk_ready = 1'b1;
        @(negedge clock);
        chk("release_col_ready", 64'(col_ready), 64'd1);
        @(posedge clock); #1;
        col_valid = 1'b0;
        chk("release_in_block", 64'(in_block), 64'd1);
        chk("release_part1", part1_result, 64'd33210);
        chk("release_drained", 64'(blk_valid), 64'd0);

        send(12'h842, 3'b000, 0, 0, 0, 0);
        exp_q.push_back({64'd490, 64'd625});
        send(12'h008, 3'b110, 0, 0, 1, 0);
        // Block 3: 51/387/215 multiply
        send(12'h230, 3'b001, 1, 0, 0, 0);
        send(12'h185, 3'b000, 0, 1, 0, 0);
        exp_q.push_back({64'd4243455, 64'd3253600});
        send(12'h571, 3'b000, 0, 1, 1, 0);
        // Block 4: 64/23/314 add, last of frame
        send(12'h326, 3'b000, 1, 1, 0, 0);
        send(12'h134, 3'b000, 0, 0, 0, 0);
        exp_q.push_back({64'd401, 64'd1058});
        send(12'h400, 3'b011, 0, 0, 1, 1);
        chk("frame_part1", part1_result, 64'd4277556);
        chk("frame_part2", part2_result, 64'd3263827);
        chk("frame_count", 64'(block_count), 64'd4);
        chk("frame_done", 64'(done_), 64'd1);
        chk("frame_overflow", 64'(overflow), 64'd0);
        @(negedge clock);
        chk("done_col_ready", 64'(col_ready), 64'd0);

        // Frame restart via load
        @(posedge clock); #1;
        load = 1'b1;
        @(negedge clock);
        chk("load_col_ready", 64'(col_ready), 64'd0);
        @(posedge clock); #1;
        load = 1'b0;
        chk("load_part1", part1_result, 64'd0);
        chk("load_done", 64'(done_), 64'd0);
        chk("load_count", 64'(block_count), 64'd0);

        // Single-column add block: 7, blank, 2
        exp_q.push_back({64'd9, 64'd72});
        send(12'h207, 3'b010, 1, 1, 1, 0);
        chk("single_part2", part2_result, 64'd72);

        // Clear mid-block, with a simultaneous beat that must be dropped
        send(12'h111, 3'b000, 1, 0, 0, 0);
        col_valid = 1'b1; col_digit = 12'h999; block_start = 1'b0; col_last = 1'b1;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0; col_valid = 1'b0;
        chk("clr_part1", part1_result, 64'd0);
        chk("clr_part2", part2_result, 64'd0);
        chk("clr_count", 64'(block_count), 64'd0);
        chk("clr_in_block", 64'(in_block), 64'd0);
        chk("clr_blk_valid", 64'(blk_valid), 64'd0);
        // Implicit start: rows 14/25/36 add, columns 123+456
        exp_q.push_back({64'd75, 64'd579});
        send(12'h321, 3'b000, 0, 1, 0, 0);
        send(12'h654, 3'b000, 0, 0, 1, 0);
        chk("implicit_part1", part1_result, 64'd75);
        chk("implicit_count", 64'(block_count), 64'd1);

        // Narrow instance: 300*300 in 16 bits wraps and flags overflow
        b_col_valid = 1'b1; b_digit = 8'h33; b_space = 2'b00; b_start = 1'b1; b_plus = 1'b0;
        @(posedge clock); #1;
        b_digit = 8'h00; b_start = 1'b0;
        @(posedge clock); #1;
        b_last = 1'b1; b_flast = 1'b1;
        @(posedge clock); #1;
        b_col_valid = 1'b0; b_last = 1'b0; b_flast = 1'b0;
        chk("narrow_blk_p1", 64'(b_p1), 64'd24464);
        chk("narrow_blk_p2", 64'(b_p2), 64'd0);
        chk("narrow_overflow", 64'(b_overflow), 64'd1);
        chk("narrow_done", 64'(b_done), 64'd1);

        repeat (3) @(posedge clock);
        #1 chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/day6_solver_n.md
# day6_solver_n

Parametrised streaming solver for the Day 6 column-arithmetic puzzle. It accepts one column of `ROWS` decimal digit cells per beat and builds per-row numbers (part 1) and per-column numbers (part 2) for each block. It reduces each block with `+` or `*`, emits a per-block result stream and accumulates frame totals. It sits between the text-to-column parser and the result readout. It is the N-row, flow-controlled successor to the fixed 4-row solver, and adds backpressure, a per-block output, a block counter and overflow detection.

## Interface
- `ROWS`, 4: number of digit rows per column, 1..8.
- `W`, 64: width of every accumulator and result.
- `CNT_W`, 16: width of `block_count`.

- `clock` in 1: sole clock; all state updates on the rising edge.
- `clear` in 1: synchronous, active-high reset.
- `load` in 1: synchronous frame restart; same effect as `clear` on all state.
- `col_valid` in 1: a column beat is presented.
- `col_ready` out 1: beat accepted when `col_valid & col_ready`.
- `col_digit` in 4*ROWS: digit of row r in bits [4r+3:4r]; row 0 is the top row.
- `col_space` in ROWS: row r cell is blank; its digit is ignored.
- `block_start` in 1: this beat is the first column of a block.
- `block_plus` in 1: block operator, 1 = add, 0 = multiply; sampled on `block_start` beats only.
- `col_last` in 1: this beat is the last column of a block.
- `frame_last` in 1: with `col_last`, this block is the last of the frame.
- `blk_valid` out 1: block result register full.
- `blk_ready` in 1: consumer takes the block result.
- `blk_p1` out W: part-1 value of the block.
- `blk_p2` out W: part-2 value of the block.
- `part1_result` out W: running part-1 total.
- `part2_result` out W: running part-2 total.
- `block_count` out CNT_W: blocks completed, wraps modulo 2^CNT_W.
- `overflow` out 1: sticky; set when any add or multiply exceeded W bits.
- `in_block` out 1: a block is open.
- `done_` out 1: frame complete.

## Operation
- Accept: `acc = col_valid & col_ready`, where `col_ready = ~done_ & ~load & (~blk_valid | blk_ready)`. The `blk_ready` path to `col_ready` is combinational.
- Effective start: `s = block_start | ~in_block`. A beat arriving with no block open starts a block implicitly, and `block_plus` is sampled on it.
- Operator: `op = s ? block_plus : op_reg`.
- Row accumulators R[r] (per-row numbers): the base is 0 if `s`, else R[r]. A non-blank cell gives `base*10 + d`; a blank cell leaves `base`. Implement `*10` as `(x<<3)+(x<<1)`.
- Column number C (per-column value): fold top to bottom starting from 0; each non-blank cell gives `C = C*10 + d`. A column with all cells blank gives C = 0.
- Block part-2 accumulator B: base is (`op` ? 0 : 1) if `s`, else B. New value is `op ? base + C : base * C`, truncated to W.
- On an accepted `col_last` beat:
  - P1 = sum or product of the new R[0..ROWS-1], per `op`; product left to right, each partial product truncated to W. An all-blank row contributes 0.
  - `blk_p1` <= P1, `blk_p2` <= new B, `blk_valid` <= 1.
  - `part1_result += P1`; `part2_result += new B`.
  - `block_count` += 1; `in_block` <= 0.
  - If `frame_last` is also set, `done_` <= 1.
- Any other accepted beat sets `in_block` <= 1 and stores R, B and `op_reg`.
- `blk_valid` clears when `blk_valid & blk_ready` and no new result is loaded that cycle. Load and drain in the same cycle leaves `blk_valid` = 1 with the new data.
- Overflow: `overflow` is set on any carry-out of a W-bit add, or any nonzero upper half of a 2W-bit product. This covers the `*10` steps, B, P1 and both totals. Results wrap modulo 2^W.
- While `done_` = 1, beats are refused but a pending block result still drains.
- `clear` or `load` zeroes R, B, totals, `block_count`, `blk_*`, `op_reg`, `overflow`, `in_block` and `done_`. Either one beats a simultaneous beat, and the beat is dropped.

## Timing
- Reset value of every output: 0, except `col_ready`, which is 1 when `col_valid` is irrelevant, i.e. after reset it equals `~load`.
- All results are visible the cycle after the accepting edge: 1-cycle latency from beat to `blk_valid` and totals.
- Throughput is 1 column per cycle while `blk_ready` is high.
- No combinational path from `col_*` inputs to any output except `col_ready`.

## Structure
- Package `day6_pkg`:
  - `DIGIT_W = 4`.
  - Function `mul10(x)` with carry flag.
  - Function for a W-bit multiply with overflow.
- Sub-module `day6_row_acc`:
  - One instance per row, via generate.
  - Holds R[r] and emits next value plus overflow.
- Top level holds the column fold, block reducer, output register, totals and control.

## Test plan
- ROWS=3, puzzle example (blocks `123/45/6 *`, `328/64/98 +`, `51/387/215 *`, `64/23/314 +`), `blk_ready`=1 -> `part1_result`=4277556, `part2_result`=3263827, `block_count`=4, `done_`=1, `overflow`=0.
- Block 1 of the example alone -> `blk_p1`=33210, `blk_p2`=8544 (1*24*356), one cycle after the `col_last` beat.
- Hold `blk_ready`=0 after block 1 -> `col_ready`=0 and the next beat stalls. Raise `blk_ready` -> the beat is accepted that cycle, totals unchanged by the stall.
- ROWS=2, W=16, one `*` block with rows 300 and 300 -> `blk_p1`=24464, `overflow`=1.
- Single-column `+` block (`block_start` and `col_last` on the same beat) with digits 7,blank,2 -> `blk_p1`=9, `blk_p2`=72.
- `clear` asserted mid-block -> all outputs 0 next cycle. The following block computes as if fresh; a non-`block_start` first beat starts a block implicitly.
